// File: rtl/jala_pkg.sv
// Shared JALA stack definitions: op encoding and the legality rule used by the
// stack engine and by the control FSM for stall prediction.
package jala_pkg;

   localparam logic [2:0] STK_NOP     = 3'd0;
   localparam logic [2:0] STK_PUSH    = 3'd1;
   localparam logic [2:0] STK_POP     = 3'd2;
   localparam logic [2:0] STK_REPLACE = 3'd3;
   localparam logic [2:0] STK_SWAP    = 3'd4;
   localparam logic [2:0] STK_DUP     = 3'd5;
   localparam logic [2:0] STK_POP2    = 3'd6;
   localparam logic [2:0] STK_RSV     = 3'd7;

   // True when op can execute against the given occupancy without over/underflow.
   function automatic logic is_legal(logic [2:0] op, int unsigned count, int unsigned depth);
      logic ok;
      case (op)
         STK_PUSH:    ok = (count < depth);
         STK_DUP:     ok = (count >= 1) && (count < depth);
         STK_POP:     ok = (count >= 1);
         STK_REPLACE: ok = (count >= 1);
         STK_SWAP:    ok = (count >= 2);
         STK_POP2:    ok = (count >= 2);
         default:     ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/jala_stack_regfile.sv
// Stack entry storage: two combinational read ports (top/next) and two
// synchronous write ports; port B exists only so SWAP completes in one cycle.
module jala_stack_regfile #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              CLK,
   input  logic [ADDR_W-1:0] rdAddrA,
   input  logic [ADDR_W-1:0] rdAddrB,
   output logic [DATA_W-1:0] rdDataA,
   output logic [DATA_W-1:0] rdDataB,
   input  logic              wrEnA,
   input  logic [ADDR_W-1:0] wrAddrA,
   input  logic [DATA_W-1:0] wrDataA,
   input  logic              wrEnB,
   input  logic [ADDR_W-1:0] wrAddrB,
   input  logic [DATA_W-1:0] wrDataB
);

   logic [DATA_W-1:0] mem [DEPTH];

   assign rdDataA = mem[rdAddrA];
   assign rdDataB = mem[rdAddrB];

   // Contents deliberately have no reset; occupancy alone defines validity.
   always_ff @(posedge CLK) begin
      if (wrEnA) mem[wrAddrA] <= wrDataA;
      if (wrEnB) mem[wrAddrB] <= wrDataB;
   end

endmodule

// File: rtl/jala_hw_stack.sv
// JALA hardware stack engine: one stack op per cycle, TOS/NOS for the ALU
// operand path, sticky overflow/underflow flags.
module jala_hw_stack
   import jala_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              CLK,
   input  logic              Rst,
   input  logic [2:0]        Op,
   input  logic [DATA_W-1:0] PushData,
   input  logic              ClrErr,
   output logic [DATA_W-1:0] TOS,
   output logic [DATA_W-1:0] NOS,
   output logic [CNT_W-1:0]  Count,
   output logic              Empty,
   output logic              Full,
   output logic              Overflow,
   output logic              Underflow
);

   localparam int ADDR_W = CNT_W - 1;

   logic [CNT_W-1:0]  countReg, countNext;
   logic              overflowReg, underflowReg;
   logic              legal, setOvf, setUnf;
   logic [ADDR_W-1:0] topAddr, nextAddr, pushAddr;
   logic [DATA_W-1:0] topData, nextData;
   logic              wrEnA, wrEnB;
   logic [ADDR_W-1:0] wrAddrA, wrAddrB;
   logic [DATA_W-1:0] wrDataA, wrDataB;

   logic [CNT_W-1:0] countM1, countM2;
   assign countM1  = countReg - CNT_W'(1);
   assign countM2  = countReg - CNT_W'(2);
   assign topAddr  = countM1[ADDR_W-1:0];
   assign nextAddr = countM2[ADDR_W-1:0];
   assign pushAddr = countReg[ADDR_W-1:0];

   always_comb begin
      legal     = is_legal(Op, 32'(countReg), DEPTH);
      countNext = countReg;
      setOvf    = 1'b0;
      setUnf    = 1'b0;
      wrEnA     = 1'b0;
      wrEnB     = 1'b0;
      wrAddrA   = pushAddr;
      wrAddrB   = nextAddr;
      wrDataA   = PushData;
      wrDataB   = topData;
      if (!legal) begin
         if ((Op == STK_PUSH || Op == STK_DUP) && countReg == CNT_W'(DEPTH))
            setOvf = 1'b1;
         else
            setUnf = 1'b1;
      end else begin
         case (Op)
            STK_PUSH: begin
               wrEnA     = 1'b1;
               countNext = countReg + CNT_W'(1);
            end
            STK_POP:  countNext = countM1;
            STK_REPLACE: begin
               wrEnA   = 1'b1;
               wrAddrA = topAddr;
            end
            STK_SWAP: begin
               wrEnA   = 1'b1;
               wrAddrA = topAddr;
               wrDataA = nextData;
               wrEnB   = 1'b1;
            end
            STK_DUP: begin
               wrEnA     = 1'b1;
               wrDataA   = topData;
               countNext = countReg + CNT_W'(1);
            end
            STK_POP2: countNext = countM2;
            default:  ;
         endcase
      end
      // A write must not land on an edge that reset is discarding.
      if (Rst) begin
         wrEnA = 1'b0;
         wrEnB = 1'b0;
      end
   end

   jala_stack_regfile #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) regfile (
      .CLK     (CLK),
      .rdAddrA (topAddr),
      .rdAddrB (nextAddr),
      .rdDataA (topData),
      .rdDataB (nextData),
      .wrEnA   (wrEnA),
      .wrAddrA (wrAddrA),
      .wrDataA (wrDataA),
      .wrEnB   (wrEnB),
      .wrAddrB (wrAddrB),
      .wrDataB (wrDataB)
   );

   // A new error outranks ClrErr in the same cycle.
   always_ff @(posedge CLK or posedge Rst) begin
      if (Rst) begin
         countReg     <= '0;
         overflowReg  <= 1'b0;
         underflowReg <= 1'b0;
      end else begin
         countReg     <= countNext;
         overflowReg  <= setOvf | (overflowReg & ~ClrErr);
         underflowReg <= setUnf | (underflowReg & ~ClrErr);
      end
   end

   assign Count     = countReg;
   assign Empty     = (countReg == '0);
   assign Full      = (countReg == CNT_W'(DEPTH));
   assign Overflow  = overflowReg;
   assign Underflow = underflowReg;
   assign TOS       = (countReg >= CNT_W'(1)) ? topData  : '0;
   assign NOS       = (countReg >= CNT_W'(2)) ? nextData : '0;

endmodule

// File: tb/tb_jala_hw_stack.sv
// Directed bench for jala_hw_stack: table of single-op vectors on a DEPTH=4
// stack, async-reset sequence, then a fill/drain of a DEPTH=16 stack.
module tb_jala_hw_stack;
   import jala_pkg::*;

   logic        CLK = 1'b0;
   logic        Rst = 1'b1;
   logic [2:0]  op4 = STK_NOP, op16 = STK_NOP;
   logic [15:0] data4 = '0, data16 = '0;
   logic        clr4 = 1'b0, clr16 = 1'b0;

   logic [15:0] tos4, nos4, tos16, nos16;
   logic [2:0]  count4;
   logic [4:0]  count16;
   logic        empty4, full4, ovf4, unf4;
   logic        empty16, full16, ovf16, unf16;

   int checks = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   jala_hw_stack #(.DATA_W(16), .DEPTH(4)) dut4 (
      .CLK(CLK), .Rst(Rst), .Op(op4), .PushData(data4), .ClrErr(clr4),
      .TOS(tos4), .NOS(nos4), .Count(count4), .Empty(empty4), .Full(full4),
      .Overflow(ovf4), .Underflow(unf4)
   );

   jala_hw_stack #(.DATA_W(16), .DEPTH(16)) dut16 (
      .CLK(CLK), .Rst(Rst), .Op(op16), .PushData(data16), .ClrErr(clr16),
      .TOS(tos16), .NOS(nos16), .Count(count16), .Empty(empty16), .Full(full16),
      .Overflow(ovf16), .Underflow(unf16)
   );

   typedef struct {
      logic [2:0]  op;
      logic [15:0] data;
      logic        clr;
      logic [2:0]  cnt;
      logic [15:0] tos;
      logic [15:0] nos;
      logic        empty;
      logic        full;
      logic        ovf;
      logic        unf;
   } vec_t;

   localparam int NVEC = 31;
   vec_t vec [NVEC];

   function automatic vec_t mk(logic [2:0] op, logic [15:0] data, logic clr, logic [2:0] cnt,
                               logic [15:0] tos, logic [15:0] nos, logic empty, logic full,
                               logic ovf, logic unf);
      vec_t v;
      v.op = op; v.data = data; v.clr = clr; v.cnt = cnt; v.tos = tos; v.nos = nos;
      v.empty = empty; v.full = full; v.ovf = ovf; v.unf = unf;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic chk4(string tag, logic [2:0] cnt, logic [15:0] tos, logic [15:0] nos,
                       logic empty, logic full, logic ovf, logic unf);
      chk({tag, ".count"}, 32'(count4), 32'(cnt));
      chk({tag, ".tos"},   32'(tos4),   32'(tos));
      chk({tag, ".nos"},   32'(nos4),   32'(nos));
      chk({tag, ".empty"}, 32'(empty4), 32'(empty));
      chk({tag, ".full"},  32'(full4),  32'(full));
      chk({tag, ".ovf"},   32'(ovf4),   32'(ovf));
      chk({tag, ".unf"},   32'(unf4),   32'(unf));
   endtask

   initial begin
      vec[0]  = mk(STK_PUSH,    16'h1111, 0, 1, 16'h1111, 16'h0000, 0, 0, 0, 0);
      vec[1]  = mk(STK_PUSH,    16'h2222, 0, 2, 16'h2222, 16'h1111, 0, 0, 0, 0);
      vec[2]  = mk(STK_PUSH,    16'h3333, 0, 3, 16'h3333, 16'h2222, 0, 0, 0, 0);
      vec[3]  = mk(STK_PUSH,    16'h4444, 0, 4, 16'h4444, 16'h3333, 0, 1, 0, 0);
      vec[4]  = mk(STK_PUSH,    16'h5555, 0, 4, 16'h4444, 16'h3333, 0, 1, 1, 0);
      vec[5]  = mk(STK_NOP,     16'h0000, 1, 4, 16'h4444, 16'h3333, 0, 1, 0, 0);
      vec[6]  = mk(STK_POP,     16'h0000, 0, 3, 16'h3333, 16'h2222, 0, 0, 0, 0);
      vec[7]  = mk(STK_POP2,    16'h0000, 0, 1, 16'h1111, 16'h0000, 0, 0, 0, 0);
      vec[8]  = mk(STK_PUSH,    16'h2222, 0, 2, 16'h2222, 16'h1111, 0, 0, 0, 0);
      vec[9]  = mk(STK_SWAP,    16'h0000, 0, 2, 16'h1111, 16'h2222, 0, 0, 0, 0);
      vec[10] = mk(STK_DUP,     16'h0000, 0, 3, 16'h1111, 16'h1111, 0, 0, 0, 0);
      vec[11] = mk(STK_REPLACE, 16'hBEEF, 0, 3, 16'hBEEF, 16'h1111, 0, 0, 0, 0);
      vec[12] = mk(STK_POP2,    16'h0000, 0, 1, 16'h2222, 16'h0000, 0, 0, 0, 0);
      vec[13] = mk(STK_POP2,    16'h0000, 0, 1, 16'h2222, 16'h0000, 0, 0, 0, 1);
      vec[14] = mk(STK_POP,     16'h0000, 1, 0, 16'h0000, 16'h0000, 1, 0, 0, 0);
      vec[15] = mk(STK_POP,     16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 1);
      vec[16] = mk(STK_POP,     16'h0000, 1, 0, 16'h0000, 16'h0000, 1, 0, 0, 1);
      vec[17] = mk(STK_NOP,     16'h0000, 1, 0, 16'h0000, 16'h0000, 1, 0, 0, 0);
      vec[18] = mk(STK_DUP,     16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 1);
      vec[19] = mk(STK_RSV,     16'h9999, 1, 0, 16'h0000, 16'h0000, 1, 0, 0, 0);
      vec[20] = mk(STK_SWAP,    16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 1);
      vec[21] = mk(STK_NOP,     16'h0000, 1, 0, 16'h0000, 16'h0000, 1, 0, 0, 0);
      vec[22] = mk(STK_PUSH,    16'h0A0A, 0, 1, 16'h0A0A, 16'h0000, 0, 0, 0, 0);
      vec[23] = mk(STK_DUP,     16'h0000, 0, 2, 16'h0A0A, 16'h0A0A, 0, 0, 0, 0);
      vec[24] = mk(STK_DUP,     16'h0000, 0, 3, 16'h0A0A, 16'h0A0A, 0, 0, 0, 0);
      vec[25] = mk(STK_DUP,     16'h0000, 0, 4, 16'h0A0A, 16'h0A0A, 0, 1, 0, 0);
      vec[26] = mk(STK_DUP,     16'h0000, 0, 4, 16'h0A0A, 16'h0A0A, 0, 1, 1, 0);
      vec[27] = mk(STK_REPLACE, 16'h1234, 1, 4, 16'h1234, 16'h0A0A, 0, 1, 0, 0);
      vec[28] = mk(STK_SWAP,    16'h0000, 0, 4, 16'h0A0A, 16'h1234, 0, 1, 0, 0);
      vec[29] = mk(STK_PUSH,    16'h7777, 0, 4, 16'h0A0A, 16'h1234, 0, 1, 1, 0);
      vec[30] = mk(STK_POP,     16'h0000, 0, 3, 16'h1234, 16'h0A0A, 0, 0, 1, 0);

      repeat (2) @(posedge CLK);
      @(negedge CLK);
      Rst = 1'b0;
      chk4("reset", 3'd0, 16'h0, 16'h0, 1, 0, 0, 0);

      for (int i = 0; i < NVEC; i++) begin
         op4 = vec[i].op; data4 = vec[i].data; clr4 = vec[i].clr;
         @(posedge CLK);
         #1;
         chk4($sformatf("vec%0d", i), vec[i].cnt, vec[i].tos, vec[i].nos,
              vec[i].empty, vec[i].full, vec[i].ovf, vec[i].unf);
         $display("vec%0d op=%0d data=%h clr=%0b -> count=%0d tos=%h nos=%h ovf=%0b unf=%0b",
                  i, vec[i].op, vec[i].data, vec[i].clr, count4, tos4, nos4, ovf4, unf4);
      end

      // Async reset mid-cycle with a PUSH pending: state clears immediately, push discarded.
      op4 = STK_PUSH; data4 = 16'h7777; clr4 = 1'b0;
      @(negedge CLK);
      Rst = 1'b1;
      #1;
      chk4("arst_now", 3'd0, 16'h0, 16'h0, 1, 0, 0, 0);
      @(posedge CLK);
      #1;
      chk4("arst_edge", 3'd0, 16'h0, 16'h0, 1, 0, 0, 0);
      @(negedge CLK);
      Rst = 1'b0;
      op4 = STK_NOP;
      @(posedge CLK);
      #1;
      chk4("arst_after", 3'd0, 16'h0, 16'h0, 1, 0, 0, 0);
      $display("arst count=%0d empty=%0b ovf=%0b unf=%0b", count4, empty4, ovf4, unf4);

      // DEPTH=16 fill, overflow, drain: checks the 5-bit count reaches 5'b10000.
      for (int i = 0; i < 16; i++) begin
         op16 = STK_PUSH; data16 = 16'(i * 16'h0101 + 1);
         @(posedge CLK);
         #1;
         chk($sformatf("d16_push%0d.count", i), 32'(count16), 32'(i + 1));
         chk($sformatf("d16_push%0d.tos", i), 32'(tos16), 32'(16'(i * 16'h0101 + 1)));
         chk($sformatf("d16_push%0d.full", i), 32'(full16), 32'(i == 15));
         $display("d16 push%0d -> count=%0d tos=%h full=%0b", i, count16, tos16, full16);
      end
      op16 = STK_PUSH; data16 = 16'hDEAD;
      @(posedge CLK);
      #1;
      chk("d16_ovf.count", 32'(count16), 32'(5'b10000));
      chk("d16_ovf.flag", 32'(ovf16), 32'd1);
      chk("d16_ovf.tos", 32'(tos16), 32'(16'(15 * 16'h0101 + 1)));
      $display("d16 push-over -> count=%0d ovf=%0b", count16, ovf16);
      for (int i = 15; i >= 0; i--) begin
         op16 = STK_POP;
         @(posedge CLK);
         #1;
         chk($sformatf("d16_pop%0d.count", i), 32'(count16), 32'(i));
         chk($sformatf("d16_pop%0d.tos", i), 32'(tos16), (i == 0) ? 32'd0 : 32'(16'((i - 1) * 16'h0101 + 1)));
         $display("d16 pop -> count=%0d tos=%h", count16, tos16);
      end
      chk("d16_end.empty", 32'(empty16), 32'd1);
      op16 = STK_NOP;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/jala_hw_stack.md
Name: jala_hw_stack

Overview:
- Parametrised hardware stack engine; next generation of the separate MSP/RSP stack-pointer registers in the JALA datapath.
- Holds stack contents on-chip and exposes top (TOS) and next-of-stack (NOS) to the ALU operand path (ValA/ValB).
- Executes one stack op per cycle and flags overflow/underflow.
- Instantiated twice at the integration level: once as the memory stack, once as the return stack (DEPTH differs).

Parameters:
- DATA_W, 16, width of each stack entry.
- DEPTH, 16, number of entries; must be a power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Op  in  3  stack operation code, sampled every rising edge.
- PushData  in  DATA_W  value written by PUSH / REPLACE.
- ClrErr  in  1  synchronous clear of the sticky error flags.
- TOS  out  DATA_W  top entry; 0 when Count < 1.
- NOS  out  DATA_W  second entry; 0 when Count < 2.
- Count  out  CNT_W  current occupancy, 0..DEPTH.
- Empty  out  1  Count == 0.
- Full  out  1  Count == DEPTH.
- Overflow  out  1  sticky; set by a rejected op that would exceed DEPTH.
- Underflow  out  1  sticky; set by a rejected op that needs more entries than present.

Behaviour:
- Reset (async, immediate): Count=0, Overflow=0, Underflow=0. TOS=0, NOS=0, Empty=1, Full=0. Entry storage is not cleared.
- Op codes:
  - NOP=0: no change.
  - PUSH=1: mem[Count]<=PushData, Count+1.
  - POP=2: Count-1.
  - REPLACE=3: mem[Count-1]<=PushData, Count unchanged (pop+push in one cycle).
  - SWAP=4: exchange mem[Count-1] and mem[Count-2].
  - DUP=5: mem[Count]<=mem[Count-1], Count+1.
  - POP2=6: Count-2.
  - RSV=7: treated as NOP.
- Latency: state updates on the edge where Op is sampled. TOS/NOS/Count/flags are combinational from state, so they reflect the op in the following cycle.
- Legality checks are made against Count before the edge:
  - PUSH needs Count<DEPTH.
  - DUP needs 1<=Count<DEPTH.
  - POP and REPLACE need Count>=1.
  - SWAP and POP2 need Count>=2.
- Illegal op: storage and Count unchanged. Overflow<=1 if the op fails the full check (PUSH, or DUP with Count==DEPTH); otherwise Underflow<=1. DUP on empty sets Underflow.
- Sticky flags stay set until ClrErr or Rst.
- ClrErr and a new error in the same cycle: the error wins and the flag ends at 1.
- Wrap-around: Count never wraps. It saturates by rejection, so CNT_W is wide enough to represent DEPTH exactly.
- Reset mid-operation: an op sampled on the same edge that Rst is asserted is discarded.
- X-safety: Op, PushData and ClrErr are ignored while Rst=1.

Decomposition:
- Shared package jala_pkg holds the op encoding as localparams (STK_NOP..STK_RSV, 3 bits).
- The same package holds the legality helper function is_legal(op, count, depth), which the control FSM reuses to predict stalls.
- One sub-module, jala_stack_regfile: DEPTH x DATA_W register array with two combinational read ports (Count-1, Count-2) and two synchronous write ports. The second write port is used only by SWAP.
- The top level holds Count, the flags and the op decode.

Test Plan (DATA_W=16, DEPTH=4 unless noted):
- Reset then PUSH 0x1111, 0x2222, 0x3333 -> Count=3, TOS=0x3333, NOS=0x2222, Empty=0, Full=0.
- Continue PUSH 0x4444, then PUSH 0x5555 -> after the 4th push Full=1, TOS=0x4444. The 5th push leaves TOS=0x4444, Count=4 and sets Overflow=1.
- From stack {0x1111,0x2222}: SWAP -> TOS=0x1111, NOS=0x2222. Then DUP -> Count=3, TOS=0x1111, NOS=0x1111. Then REPLACE 0xBEEF -> TOS=0xBEEF, Count=3.
- From Count=1: POP2 -> Count stays 1, Underflow=1. Next cycle ClrErr=1 with Op=POP -> Count=0, Underflow=0. Then POP -> Underflow=1, Empty=1, TOS=0.
- Error-vs-clear priority: at Count=0, ClrErr=1 together with Op=POP -> Underflow=1 after the edge.
- Async reset: assert Rst mid-cycle with Count=3 and Op=PUSH -> Count=0, Empty=1 and flags=0 before the next edge. The push is not performed. Repeat the full sequence with DEPTH=16 to check counter width (Full at Count=16 = 5'b10000).
